// File: rtl/idea_dec_key_sched_if.sv
// Stream interface of the IDEA decryption key-schedule generator.
// master = key-schedule block (produces subkeys), slave = consumer/controller.
// Optional IDEA_DK_ENC_BYPASS_EN adds the 'action' direction select.
interface idea_dec_key_sched_if;
  logic         start;
  logic [0:127] key;
`ifdef IDEA_DK_ENC_BYPASS_EN
  logic         action;
`endif
  logic         busy;
  logic         dk_valid;
  logic         dk_ready;
  logic [5:0]   dk_idx;
  logic [0:15]  dk;
  logic         done;

`ifdef IDEA_DK_ENC_BYPASS_EN
  modport master (
    input  start, key, action, dk_ready,
    output busy, dk_valid, dk_idx, dk, done
  );
  modport slave (
    output start, key, action, dk_ready,
    input  busy, dk_valid, dk_idx, dk, done
  );
`else
  modport master (
    input  start, key, dk_ready,
    output busy, dk_valid, dk_idx, dk, done
  );
  modport slave (
    output start, key, dk_ready,
    input  busy, dk_valid, dk_idx, dk, done
  );
`endif
endinterface

// File: rtl/idea_dec_key_sched.sv
// IDEA decryption subkey generator: streams DK[0..6*ROUNDS+3] from a 128-bit user key.
// Latency: 32 cycles start->first subkey (inverse), 3 cycles per non-inverse subkey; stalls in OUT.
// Backpressure: dk/dk_idx held stable while dk_valid & !dk_ready. Macro IDEA_DK_ENC_BYPASS_EN adds 'action'.
module idea_dec_key_sched #(
  parameter int ROUNDS = 8
) (
  input logic                  clk,
  input logic                  rst,
  idea_dec_key_sched_if.master bus
);

  localparam int N = 6 * ROUNDS + 4;
  localparam logic [5:0] LAST_K = 6'(N - 1);
  localparam logic [4:0] INV_LAST = 5'd29;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_INV,
    S_SIMPLE,
    S_OUT,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS,
    OP_NEG,
    OP_INV
  } op_t;

  state_t state, state_nx;

  logic [127:0] key_q;
  logic [5:0]   k_q;
  logic [3:0]   r_q;      // round group of k (k / 6)
  logic [2:0]   j_q;      // position within the group (k % 6)
  logic [15:0]  x_q;      // source encryption subkey for the current k
  logic [15:0]  acc_q;    // exponentiation accumulator
  logic [4:0]   icnt_q;   // multiplier step counter inside INV
  logic [15:0]  dk_q;
  op_t          op_q;
`ifdef IDEA_DK_ENC_BYPASS_EN
  logic         action_q;
`endif

  // Multiplication mod 65537 where 16'h0000 stands for 65536.
  function automatic logic [15:0] mul_mod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] lo, hi;
    p  = {16'd0, a} * {16'd0, b};
    lo = p[15:0];
    hi = p[31:16];
    if (a == 16'd0)
      mul_mod = 16'd1 - b;
    else if (b == 16'd0)
      mul_mod = 16'd1 - a;
    else
      mul_mod = lo - hi + {15'd0, (lo < hi)};
  endfunction

  // Select the source encryption subkey index and operation for DK[k].
  logic [5:0] src_idx;
  op_t        op_sel;
  logic [5:0] s6;
  logic       edge_r;
  always_comb begin
    src_idx = 6'd0;
    op_sel  = OP_PASS;
    s6      = 6'(6 * (ROUNDS - int'(r_q)));
    edge_r  = (r_q == 4'd0) || (int'(r_q) == ROUNDS);
    case (j_q)
      3'd0: begin src_idx = s6;                             op_sel = OP_INV;  end
      3'd1: begin src_idx = edge_r ? s6 + 6'd1 : s6 + 6'd2; op_sel = OP_NEG;  end
      3'd2: begin src_idx = edge_r ? s6 + 6'd2 : s6 + 6'd1; op_sel = OP_NEG;  end
      3'd3: begin src_idx = s6 + 6'd3;                      op_sel = OP_INV;  end
      3'd4: begin src_idx = s6 - 6'd2;                      op_sel = OP_PASS; end
      default: begin src_idx = s6 - 6'd1;                   op_sel = OP_PASS; end
    endcase
`ifdef IDEA_DK_ENC_BYPASS_EN
    if (action_q) begin
      src_idx = k_q;
      op_sel  = OP_PASS;
    end
`endif
  end

  // EK[i]: 16-bit word (i % 8) of the latched key rotated left by 25*(i/8).
  logic [6:0]   rot_amt;
  logic [127:0] key_rot;
  logic [127:0] key_word_sh;
  logic [15:0]  ek_word;
  always_comb begin
    rot_amt     = {4'd0, src_idx[5:3]} * 7'd25;
    key_rot     = (rot_amt == 7'd0) ? key_q :
                  ((key_q << rot_amt) | (key_q >> (8'd128 - {1'b0, rot_amt})));
    key_word_sh = key_rot >> {src_idx[2:0] ^ 3'd7, 4'd0};
    ek_word     = key_word_sh[15:0];
  end

  // Shared multiplier: even steps square, odd steps multiply by x (x^65535 after 30 steps).
  logic [15:0] mul_y;
  always_comb begin
    mul_y = mul_mod(acc_q, icnt_q[0] ? x_q : acc_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and status outputs (all decoded from the state register).
  always_comb begin
    state_nx     = state;
    bus.busy     = 1'b0;
    bus.dk_valid = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_SEL;
      end
      S_SEL: begin
        bus.busy = 1'b1;
        state_nx = (op_sel == OP_INV) ? S_INV : S_SIMPLE;
      end
      S_INV: begin
        bus.busy = 1'b1;
        if (icnt_q == INV_LAST) state_nx = S_OUT;
      end
      S_SIMPLE: begin
        bus.busy = 1'b1;
        state_nx = S_OUT;
      end
      S_OUT: begin
        bus.busy     = 1'b1;
        bus.dk_valid = 1'b1;
        if (bus.dk_ready) state_nx = (k_q == LAST_K) ? S_FIN : S_SEL;
      end
      S_FIN: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: key latch, index counters, operand capture, inversion and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      k_q      <= '0;
      r_q      <= '0;
      j_q      <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      icnt_q   <= '0;
      dk_q     <= '0;
      op_q     <= OP_PASS;
`ifdef IDEA_DK_ENC_BYPASS_EN
      action_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            key_q    <= bus.key;
            k_q      <= '0;
            r_q      <= '0;
            j_q      <= '0;
`ifdef IDEA_DK_ENC_BYPASS_EN
            action_q <= bus.action;
`endif
          end
        end
        S_SEL: begin
          x_q    <= ek_word;
          acc_q  <= ek_word;
          op_q   <= op_sel;
          icnt_q <= '0;
        end
        S_INV: begin
          acc_q  <= mul_y;
          icnt_q <= icnt_q + 5'd1;
          if (icnt_q == INV_LAST) dk_q <= mul_y;
        end
        S_SIMPLE: begin
          dk_q <= (op_q == OP_NEG) ? (~x_q + 16'd1) : x_q;
        end
        S_OUT: begin
          if (bus.dk_ready && (k_q != LAST_K)) begin
            k_q <= k_q + 6'd1;
            if (j_q == 3'd5) begin
              j_q <= 3'd0;
              r_q <= r_q + 4'd1;
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dk     = dk_q;
  assign bus.dk_idx = k_q;

endmodule

// File: tb/tb_idea_dec_key_sched.sv
// Self-checking bench for idea_dec_key_sched (decryption order, default build).
// Reference: subkeys computed from the key with plain arithmetic (rotation, Euclid inverse).
// Stimulus: directed keys plus random keys, random dk_ready, spurious starts, mid-run reset.
module tb_idea_dec_key_sched;
  localparam int R = 8;
  localparam int N = 6 * R + 4;

  logic clk = 1'b0;
  logic rst;

  idea_dec_key_sched_if sif ();

  idea_dec_key_sched #(.ROUNDS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_dk [N];
  logic [15:0] got_dk [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ek_ref(input logic [127:0] kv, input int i);
    int sh;
    logic [127:0] r;
    sh = (25 * (i / 8)) % 128;
    r  = (sh == 0) ? kv : ((kv << sh) | (kv >> (128 - sh)));
    return r[127 - 16 * (i % 8) -: 16];
  endfunction

  function automatic logic [15:0] neg_ref(input logic [15:0] v);
    int t;
    t = (65536 - int'(v)) % 65536;
    return 16'(t);
  endfunction

  function automatic logic [15:0] inv_ref(input logic [15:0] v);
    longint r0, r1, s0, s1, q, tmp;
    r0 = 65537;
    r1 = (v == 16'd0) ? 65536 : longint'(v);
    s0 = 0;
    s1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = s0 - q * s1; s0 = s1; s1 = tmp;
    end
    s0 = s0 % 65537;
    if (s0 < 0) s0 = s0 + 65537;
    return (s0 == 65536) ? 16'h0000 : s0[15:0];
  endfunction

  task automatic build_model(input logic [127:0] kv);
    int s;
    for (int r = 0; r <= R; r++) begin
      s = R - r;
      exp_dk[6*r+0] = inv_ref(ek_ref(kv, 6*s+0));
      exp_dk[6*r+3] = inv_ref(ek_ref(kv, 6*s+3));
      if (r == 0 || r == R) begin
        exp_dk[6*r+1] = neg_ref(ek_ref(kv, 6*s+1));
        exp_dk[6*r+2] = neg_ref(ek_ref(kv, 6*s+2));
      end else begin
        exp_dk[6*r+1] = neg_ref(ek_ref(kv, 6*s+2));
        exp_dk[6*r+2] = neg_ref(ek_ref(kv, 6*s+1));
      end
      if (r < R) begin
        exp_dk[6*r+4] = ek_ref(kv, 6*(s-1)+4);
        exp_dk[6*r+5] = ek_ref(kv, 6*(s-1)+5);
      end
    end
  endtask

  // One full generation run; all sampling/driving on the falling edge.
  task automatic run_stream(input logic [127:0] kv, input bit rnd_ready,
                            input int stall_k, input bit chk_lat);
    int cyc, got, ndone, first, stall_n;
    bit pv, phs, rdy, hs;
    logic [15:0] pdk;
    logic [5:0] pidx;
    build_model(kv);
    @(negedge clk);
    sif.key = kv; sif.start = 1'b1; sif.dk_ready = 1'b0;
    cyc = 0; got = 0; ndone = 0; first = -1; stall_n = 0;
    pv = 0; phs = 0; pdk = '0; pidx = '0;
    while (cyc < 6000 && ndone == 0) begin
      @(negedge clk);
      cyc++;
      sif.start = sif.busy && ($urandom_range(0, 3) == 0);
      if (sif.busy) sif.key = {$urandom, $urandom, $urandom, $urandom};
      if (sif.done) begin
        ndone++;
        chk("done_busy", 64'(sif.busy), 64'd0);
        chk("done_valid", 64'(sif.dk_valid), 64'd0);
      end
      if (sif.dk_valid && first < 0) first = cyc;
      if (pv && !phs) begin
        chk("hold_valid", 64'(sif.dk_valid), 64'd1);
        chk("hold_dk", 64'(sif.dk), 64'(pdk));
        chk("hold_idx", 64'(sif.dk_idx), 64'(pidx));
      end
      if (sif.dk_valid && got == stall_k && stall_n < 10) begin
        rdy = 1'b0;
        stall_n++;
      end else begin
        rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      sif.dk_ready = rdy;
      hs = sif.dk_valid && rdy;
      if (hs) begin
        if (got < N) begin
          chk("dk_idx", 64'(sif.dk_idx), 64'(got));
          chk("dk", 64'(sif.dk), 64'(exp_dk[got]));
          got_dk[got] = sif.dk;
        end
        got++;
      end
      pv = sif.dk_valid; phs = hs; pdk = sif.dk; pidx = sif.dk_idx;
    end
    sif.start = 1'b0;
    sif.dk_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sif.done) ndone++;
    end
    chk("done_count", 64'(ndone), 64'd1);
    chk("subkey_count", 64'(got), 64'(N));
    if (chk_lat) chk("first_latency", 64'(first), 64'd32);
    if (stall_k >= 0) chk("stall_len", 64'(stall_n), 64'd10);
  endtask

  initial begin
    logic [127:0] kv;
    int cnt, ndone;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.key = '0;
    sif.dk_ready = 1'b0;
`ifdef IDEA_DK_ENC_BYPASS_EN
    sif.action = 1'b0;
`endif
    #1;
    chk("rst_busy", 64'(sif.busy), 64'd0);
    chk("rst_valid", 64'(sif.dk_valid), 64'd0);
    chk("rst_idx", 64'(sif.dk_idx), 64'd0);
    chk("rst_dk", 64'(sif.dk), 64'd0);
    chk("rst_done", 64'(sif.done), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // All-zero key: every subkey is zero.
    run_stream(128'h0, 1'b0, -1, 1'b1);
    chk("zero_dk0", 64'(got_dk[0]), 64'd0);
    chk("zero_dk51", 64'(got_dk[51]), 64'd0);

    kv = 128'h0001_0001_0001_0001_0001_0001_0001_0001;
    run_stream(kv, 1'b0, -1, 1'b1);
    chk("ones_dk48", 64'(got_dk[48]), 64'h0001);
    chk("ones_dk49", 64'(got_dk[49]), 64'hFFFF);
    chk("ones_dk50", 64'(got_dk[50]), 64'hFFFF);
    chk("ones_dk51", 64'(got_dk[51]), 64'h0001);

    kv = 128'h0002_0003_0000_0000_0000_0000_0000_0000;
    run_stream(kv, 1'b1, -1, 1'b0);
    chk("inv2_dk48", 64'(got_dk[48]), 64'h8001);
    chk("neg3_dk49", 64'(got_dk[49]), 64'hFFFD);

    // Random key, 10-cycle stall at k=5, random backpressure.
    kv = {$urandom, $urandom, $urandom, $urandom};
    run_stream(kv, 1'b1, 5, 1'b1);

    // Reset while DK[3] is being inverted.
    kv = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    sif.key = kv; sif.start = 1'b1; sif.dk_ready = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    cnt = 0;
    while (cnt < 300 && !(sif.dk_valid && sif.dk_idx == 6'd2)) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_k2", 64'(sif.dk_idx), 64'd2);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(sif.busy), 64'd0);
    chk("mid_rst_valid", 64'(sif.dk_valid), 64'd0);
    chk("mid_rst_idx", 64'(sif.dk_idx), 64'd0);
    chk("mid_rst_dk", 64'(sif.dk), 64'd0);
    chk("mid_rst_done", 64'(sif.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (sif.done || sif.busy) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    run_stream(kv, 1'b1, -1, 1'b1);

    kv = {$urandom, $urandom, $urandom, $urandom};
    run_stream(kv, 1'b0, 17, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
